sim_ctrl_port: RTL

SIM_CTRL_PORT -- requirements
Module: sim_ctrl_port

---
 rtl/sim_ctrl_pkg.sv | 14 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/sim_ctrl_port.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and default address map for the simulation control port.
package sim_ctrl_pkg;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_0FF0;
  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_0FF4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } sim_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push while full is taken only
// when a pop happens on the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Head reads as zero when empty so the consumer never sees stale bytes.
  assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sim_ctrl_port.sv
// Snoops CPU stores to end a simulated test (tohost) and to stream console
// bytes out through a small FIFO, with a run-cycle watchdog.
module sim_ctrl_port
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
  parameter logic [31:0] CONSOLE_ADDR   = DEFAULT_CONSOLE_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_write_en,
  input  logic [31:0] memory_write_address,
  input  logic [31:0] memory_write,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        timed_out,
  output logic        overflow,
  output logic [31:0] cycle_count,
  output logic [1:0]  state_dbg
);

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  sim_state_e  state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        pass_q, pass_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic        overflow_q, overflow_d;

  logic        store_ok;
  logic        tohost_hit;
  logic        console_hit;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] count_inc;

  // Console handshake: a byte transfers on every posedge where char_valid and
  // char_ready are both high; char_data is stable while valid waits on ready.
  assign char_valid = !fifo_empty;
  assign fifo_pop   = char_valid && char_ready;

  assign store_ok    = (state_q == ST_RUN) && memory_write_en;
  assign tohost_hit  = store_ok && (memory_write_address == TOHOST_ADDR);
  assign console_hit = store_ok && (memory_write_address == CONSOLE_ADDR);

  assign count_inc = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q
                                                      : cycle_count_q + 32'd1;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (console_hit),
    .pop   (fifo_pop),
    .din   (memory_write[7:0]),
    .dout  (char_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    pass_d        = pass_q;
    fail_code_d   = fail_code_q;
    overflow_d    = overflow_q | (console_hit && fifo_full && !fifo_pop);
    case (state_q)
      ST_RUN: begin
        cycle_count_d = count_inc;
        // A tohost store on the watchdog cycle still ends the test normally.
        if (tohost_hit) begin
          state_d     = ST_DRAIN;
          pass_d      = (memory_write == 32'd1);
          fail_code_d = (memory_write == 32'd1) ? 31'd0 : memory_write[31:1];
        end else if (count_inc == TIMEOUT_LIMIT) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cycle_count_q <= '0;
      pass_q        <= 1'b0;
      fail_code_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      pass_q        <= pass_d;
      fail_code_q   <= fail_code_d;
      overflow_q    <= overflow_d;
    end
  end

  assign done        = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
  assign timed_out   = (state_q == ST_TIMEOUT);
  assign pass        = pass_q && (state_q == ST_DONE);
  assign fail_code   = fail_code_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_count_q;
  assign state_dbg   = state_q;

endmodule
